syn_sync: RTL and testbench
===========================

Name: syn_sync

Overview:
- Brings a slow, asynchronous clock-like level (slow_clk) into the fast_clk domain.
- Uses a multi-flop synchronizer followed by an optional stability (glitch) filter.
- Produces a clean, glitch-free, fast_clk-registered copy (sync_clk) plus single-cycle rise/fall strobes.
- Sits at a slow-to-fast domain boundary; downstream fast_clk logic uses sync_clk or the strobes, never slow_clk directly.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops in series; legal range 2..8.
- FILTER_LEN, 1, consecutive fast_clk cycles the synchronized level must differ from sync_clk before sync_clk changes; legal range 1..255. A value of 1 means no filtering.

Ports:
- fast_clk  input  1  the only clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on rising fast_clk.
- slow_clk  input  1  asynchronous level to synchronize. Treated as data, never used as a clock.
- sync_clk  output  1  registered, synchronized, filtered copy of slow_clk.
- sync_rise  output  1  one-cycle pulse in the cycle sync_clk becomes 1.
- sync_fall  output  1  one-cycle pulse in the cycle sync_clk becomes 0.

Behaviour:
- Single clock domain fast_clk. Reset is synchronous and active-high. No asynchronous reset and no clock gating.
- State:
  - Shift chain s[0..SYNC_STAGES-1], with s[0] <= slow_clk and s[i] <= s[i-1].
  - Counter cnt, width max(1, clog2(FILTER_LEN)).
  - Registers sync_clk, sync_rise, sync_fall.
- Reset: while rst=1 at a rising edge, all chain stages, cnt, sync_clk, sync_rise and sync_fall go to 0. slow_clk is ignored during reset.
- Reset value of every output is 0. Before the first reset edge, outputs are undefined.
- Filter, evaluated each non-reset edge with L = s[SYNC_STAGES-1] (value before the edge):
  - If L == sync_clk: cnt <= 0, no change.
  - Else if cnt == FILTER_LEN-1: sync_clk <= L, cnt <= 0. Also sync_rise <= L and sync_fall <= ~L.
  - Else: cnt <= cnt+1.
- sync_rise and sync_fall are 0 on every edge where sync_clk does not change. They are never both 1.
- Latency: define edge E0 as the rising edge at which s[0] first captures the new slow_clk level.
  - s[SYNC_STAGES-1] holds the new level after edge E(SYNC_STAGES-1).
  - sync_clk changes after edge E(SYNC_STAGES-1+FILTER_LEN).
  - Defaults: sync_clk changes 2 edges after E0, and the strobe is high for that same cycle.
- Glitch rule: a synchronized level differing from sync_clk for fewer than FILTER_LEN consecutive cycles leaves sync_clk unchanged, with no strobe. cnt restarts from 0 on any return to equality.
- Metastability: only s[0] may sample slow_clk. No logic may read s[0..SYNC_STAGES-2].
- Reset mid-operation: takes effect at the next edge regardless of counter or strobe state.
- After reset release, a slow_clk that is already 1 produces a normal rising transition and a sync_rise pulse, with full latency.
- slow_clk with a period below about 2*(SYNC_STAGES+FILTER_LEN) fast_clk cycles is out of specification. Edges may be lost, but sync_clk stays glitch-free and the strobes stay single-cycle.

Test Plan:
- Reset: rst=1 for 8 fast_clk cycles with slow_clk toggling → sync_clk, sync_rise and sync_fall are 0 on every cycle during reset and on the first edge after release.
- Rise latency (defaults): slow_clk 0→1 mid-cycle, with E0 the next fast_clk edge → sync_clk=1 and sync_rise=1 after E2. sync_rise=0 after E3. sync_clk stays 1.
- Fall latency (defaults): slow_clk 1→0 → sync_clk=0 and sync_fall=1 exactly 2 edges after the capturing edge. Single-cycle pulse. sync_rise stays 0.
- Glitch filter (FILTER_LEN=3):
  - slow_clk high for 2 fast cycles then low → sync_clk stays 0, no strobes.
  - slow_clk high for 4 cycles → sync_clk rises after E4.
- Free-running: fast_clk period 8 ns, slow_clk period 42 ns, rst high 5–67 ns, run 1500 ns → after reset, exactly one sync_rise and one sync_fall per slow_clk period. Each sync_clk high/low phase lasts 2 or 3 fast cycles. No strobe overlaps.
- Reset mid-stream: assert rst for 1 cycle while sync_clk=1 → sync_clk=0 next edge. It re-rises with sync_rise after full latency if slow_clk is still 1.

Source files
------------

// File: rtl/syn_sync.sv
// Slow-to-fast level synchronizer: SYNC_STAGES-flop chain, then a stability
// filter that commits a new level only after FILTER_LEN consecutive differing cycles.
module syn_sync #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 1
) (
   input  logic fast_clk,
   input  logic rst,
   input  logic slow_clk,
   output logic sync_clk,
   output logic sync_rise,
   output logic sync_fall
);

   localparam int               CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   clk_q, clk_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   lvl;

   // Only the last stage is ever read; earlier stages may be metastable.
   assign lvl    = sync_q[SYNC_STAGES-1];
   assign sync_d = {sync_q[SYNC_STAGES-2:0], slow_clk};

   always_comb begin
      cnt_d  = '0;
      clk_d  = clk_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (lvl != clk_q) begin
         if (cnt_q == CNT_LAST) begin
            clk_d  = lvl;
            rise_d = lvl;
            fall_d = ~lvl;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge fast_clk) begin
      if (rst) begin
         sync_q <= '0;
         cnt_q  <= '0;
         clk_q  <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         clk_q  <= clk_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign sync_clk  = clk_q;
   assign sync_rise = rise_q;
   assign sync_fall = fall_q;

endmodule

// File: tb/tb_syn_sync.sv
// Bench for syn_sync: three parameterisations share one slow_clk/rst and are
// compared every cycle against a history-based reference model.
`timescale 1ns/100ps
module tb_syn_sync;

   logic fast_clk = 1'b0;
   logic rst      = 1'b1;
   logic slow_clk = 1'b0;

   logic c0, r0, f0, c1, r1, f1, c2, r2, f2;
   logic [2:0] oc, orr, ofl;
   assign oc  = {c2, c1, c0};
   assign orr = {r2, r1, r0};
   assign ofl = {f2, f1, f0};

   always #4 fast_clk = ~fast_clk;

   syn_sync dut_a (
      .fast_clk(fast_clk), .rst(rst), .slow_clk(slow_clk),
      .sync_clk(c0), .sync_rise(r0), .sync_fall(f0));

   syn_sync #(.SYNC_STAGES(2), .FILTER_LEN(3)) dut_b (
      .fast_clk(fast_clk), .rst(rst), .slow_clk(slow_clk),
      .sync_clk(c1), .sync_rise(r1), .sync_fall(f1));

   syn_sync #(.SYNC_STAGES(4), .FILTER_LEN(5)) dut_c (
      .fast_clk(fast_clk), .rst(rst), .slow_clk(slow_clk),
      .sync_clk(c2), .sync_rise(r2), .sync_fall(f2));

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: the filter sees slow_clk as sampled S edges earlier
   // (zero if that sample predates reset release) and commits after F in a row.
   int  S [3] = '{2, 2, 4};
   int  F [3] = '{1, 3, 5};
   bit  samp[$];
   int  n_edge = 0;
   int  nr     = 0;
   int  run [3];
   bit  mclk[3], mrise[3], mfall[3];

   bit  track = 1'b0, have_prev = 1'b0;
   bit  prev_a;
   int  len_a;

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model();
      bit lvl;
      samp.push_back(slow_clk);
      if (rst) begin
         nr = n_edge + 1;
         for (int k = 0; k < 3; k++) begin
            run[k] = 0; mclk[k] = 0; mrise[k] = 0; mfall[k] = 0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            lvl = (n_edge - S[k] >= nr) ? samp[n_edge - S[k]] : 1'b0;
            mrise[k] = 0;
            mfall[k] = 0;
            if (lvl == mclk[k]) run[k] = 0;
            else begin
               run[k]++;
               if (run[k] == F[k]) begin
                  mclk[k] = lvl; mrise[k] = lvl; mfall[k] = !lvl; run[k] = 0;
               end
            end
         end
      end
      n_edge++;
   endtask

   task automatic tick();
      @(posedge fast_clk);
      model();
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("sync_clk[%0d]", k), oc[k], mclk[k]);
         chk($sformatf("sync_rise[%0d]", k), orr[k], mrise[k]);
         chk($sformatf("sync_fall[%0d]", k), ofl[k], mfall[k]);
         chk($sformatf("no_overlap[%0d]", k), orr[k] & ofl[k], 1'b0);
      end
      if (track) begin
         if (oc[0] !== prev_a) begin
            if (have_prev) chk("phase_len_a", (len_a == 2 || len_a == 3), 1'b1);
            have_prev = 1'b1;
            len_a     = 1;
            prev_a    = oc[0];
         end else len_a++;
      end
   endtask

   initial begin
      // Reset with slow_clk toggling
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         slow_clk = i[0];
         tick();
         chk("rst_clk", c0, 1'b0);
      end
      slow_clk = 1'b0;
      rst = 1'b0;
      tick();
      chk("post_rst_clk", c0, 1'b0);
      repeat (4) tick();

      // Rise latency, defaults
      slow_clk = 1'b1;
      tick(); tick(); tick();
      chk("rise_lat_clk_a", c0, 1'b1);
      chk("rise_lat_strb_a", r0, 1'b1);
      tick();
      chk("rise_pulse_end_a", r0, 1'b0);
      chk("rise_hold_a", c0, 1'b1);
      repeat (10) tick();

      // Fall latency, defaults
      slow_clk = 1'b0;
      tick(); tick(); tick();
      chk("fall_lat_clk_a", c0, 1'b0);
      chk("fall_lat_strb_a", f0, 1'b1);
      chk("fall_no_rise_a", r0, 1'b0);
      tick();
      chk("fall_pulse_end_a", f0, 1'b0);
      repeat (12) tick();

      // Glitch of 2 cycles is filtered by FILTER_LEN=3
      slow_clk = 1'b1;
      tick(); tick();
      slow_clk = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("glitch_clk_b", c1, 1'b0);
         chk("glitch_rise_b", r1, 1'b0);
      end
      // 4-cycle pulse passes, rising after E4
      slow_clk = 1'b1;
      tick(); tick(); tick(); tick();
      slow_clk = 1'b0;
      tick();
      chk("pulse4_clk_b", c1, 1'b1);
      chk("pulse4_rise_b", r1, 1'b1);
      repeat (14) tick();

      // Reset mid-stream while sync_clk is high
      slow_clk = 1'b1;
      repeat (14) tick();
      chk("pre_midrst_clk_a", c0, 1'b1);
      rst = 1'b1;
      tick();
      chk("midrst_clk_a", c0, 1'b0);
      rst = 1'b0;
      tick(); tick();
      chk("midrst_wait_a", c0, 1'b0);
      tick();
      chk("midrst_rerise_a", r0, 1'b1);
      repeat (10) tick();

      // Random levels and hold times, with occasional resets
      for (int i = 0; i < 120; i++) begin
         slow_clk = ~slow_clk;
         repeat ($urandom_range(1, 14)) tick();
         if ($urandom_range(0, 15) == 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
      end

      // Free-running: 42 ns slow period against 8 ns fast clock
      rst = 1'b1;
      slow_clk = 1'b0;
      fork
         begin
            #0.5;
            repeat (70) #21 slow_clk = ~slow_clk;
         end
         begin
            repeat (8) tick();
            rst = 1'b0;
            prev_a = c0;
            have_prev = 1'b0;
            len_a = 0;
            track = 1'b1;
            repeat (175) tick();
            track = 1'b0;
         end
      join
      repeat (10) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
